// File: rtl/microcode_sequencer.sv
// Micro-program counter sequencer for the microcode ROM.
// Resolves branch fields, return stack, dispatch, bus-wait, halt and exception redirect.
module microcode_sequencer #(
    parameter logic [8:0] RESET_VECTOR     = 9'h000,
    parameter logic [8:0] EXCEPTION_VECTOR = 9'h1F0,
    parameter logic [8:0] ERROR_VECTOR     = 9'h1FF,
    parameter int         STACK_DEPTH      = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic [8:0] micro_pc,
    output logic [8:0] upc,
    input  logic [3:0] branch_type,
    input  logic [8:0] branch_target,
    input  logic [2:0] cond_sel,
    input  logic [7:0] cond_flags,
    input  logic [8:0] decoder_entry,
    input  logic       decoder_valid,
    input  logic       bus_busy,
    input  logic       exception_req,
    output logic       dispatch_ack,
    output logic [2:0] stack_level,
    output logic       halted,
    output logic       stack_error
);

    localparam int SPW  = $clog2(STACK_DEPTH + 1);
    localparam int IDXW = $clog2(STACK_DEPTH);

    localparam logic [3:0] BT_NEXT     = 4'd0;
    localparam logic [3:0] BT_JUMP     = 4'd1;
    localparam logic [3:0] BT_JUMP_IF  = 4'd2;
    localparam logic [3:0] BT_JUMP_IFN = 4'd3;
    localparam logic [3:0] BT_CALL     = 4'd4;
    localparam logic [3:0] BT_RETURN   = 4'd5;
    localparam logic [3:0] BT_DISPATCH = 4'd6;
    localparam logic [3:0] BT_WAIT_BUS = 4'd7;
    localparam logic [3:0] BT_HALT     = 4'd8;

    logic [8:0]     upc_q;
    logic [8:0]     npc;
    logic [8:0]     upc_inc;
    logic [SPW-1:0] sp_q, sp_d;
    logic           halted_q, halted_d;
    logic           err_q, err_d;
    logic           ack;
    logic           push;
    logic           cond;
    logic           stack_full;
    logic           stack_empty;
    logic [IDXW-1:0] push_idx;
    logic [IDXW-1:0] top_idx;
    logic [8:0]     stack_q [STACK_DEPTH];

    assign upc_inc     = upc_q + 9'd1;
    assign cond        = cond_flags[cond_sel];
    assign stack_full  = (sp_q == SPW'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign push_idx    = IDXW'(sp_q);
    assign top_idx     = IDXW'(sp_q - 1'b1);

    always_comb begin
        npc      = upc_inc;
        sp_d     = sp_q;
        halted_d = halted_q;
        err_d    = err_q;
        ack      = 1'b0;
        push     = 1'b0;
        if (halted_q) begin
            npc = upc_q;
        end else if (exception_req) begin
            npc  = EXCEPTION_VECTOR;
            sp_d = '0;
        end else begin
            case (branch_type)
                BT_NEXT:     npc = upc_inc;
                BT_JUMP:     npc = branch_target;
                BT_JUMP_IF:  npc = cond ? branch_target : upc_inc;
                BT_JUMP_IFN: npc = cond ? upc_inc : branch_target;
                BT_CALL: begin
                    if (stack_full) begin
                        npc   = ERROR_VECTOR;
                        err_d = 1'b1;
                    end else begin
                        npc  = branch_target;
                        push = 1'b1;
                        sp_d = sp_q + 1'b1;
                    end
                end
                BT_RETURN: begin
                    if (stack_empty) begin
                        npc   = ERROR_VECTOR;
                        err_d = 1'b1;
                    end else begin
                        npc  = stack_q[top_idx];
                        sp_d = sp_q - 1'b1;
                    end
                end
                BT_DISPATCH: begin
                    npc = decoder_valid ? decoder_entry : upc_q;
                    ack = decoder_valid;
                end
                BT_WAIT_BUS: npc = bus_busy ? upc_q : upc_inc;
                BT_HALT: begin
                    npc      = upc_q;
                    halted_d = 1'b1;
                end
                default: begin
                    npc   = ERROR_VECTOR;
                    err_d = 1'b1;
                end
            endcase
        end
    end

    // Reset forces the ROM address combinationally so the first word is RESET_VECTOR.
    assign micro_pc     = reset_n ? npc : RESET_VECTOR;
    assign dispatch_ack = reset_n & ack;
    assign upc          = upc_q;
    assign halted       = halted_q;
    assign stack_error  = err_q;
    assign stack_level  = (sp_q > SPW'(7)) ? 3'd7 : 3'(sp_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            upc_q    <= RESET_VECTOR;
            sp_q     <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            upc_q    <= npc;
            sp_q     <= sp_d;
            halted_q <= halted_d;
            err_q    <= err_d;
            if (push) begin
                stack_q[push_idx] <= upc_inc;
            end
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Table-driven bench for microcode_sequencer with a scoreboard of
// expected registered state, plus hand-written asynchronous reset checks.
module tb_microcode_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [8:0] micro_pc;
    logic [8:0] upc;
    logic [3:0] branch_type = '0;
    logic [8:0] branch_target = '0;
    logic [2:0] cond_sel = '0;
    logic [7:0] cond_flags = '0;
    logic [8:0] decoder_entry = '0;
    logic       decoder_valid = 1'b0;
    logic       bus_busy = 1'b0;
    logic       exception_req = 1'b0;
    logic       dispatch_ack;
    logic [2:0] stack_level;
    logic       halted;
    logic       stack_error;

    microcode_sequencer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .micro_pc      (micro_pc),
        .upc           (upc),
        .branch_type   (branch_type),
        .branch_target (branch_target),
        .cond_sel      (cond_sel),
        .cond_flags    (cond_flags),
        .decoder_entry (decoder_entry),
        .decoder_valid (decoder_valid),
        .bus_busy      (bus_busy),
        .exception_req (exception_req),
        .dispatch_ack  (dispatch_ack),
        .stack_level   (stack_level),
        .halted        (halted),
        .stack_error   (stack_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         rst;
        logic [3:0] bt;
        logic [8:0] tgt;
        logic [2:0] csel;
        logic [7:0] fl;
        logic       dv;
        logic [8:0] de;
        logic       bb;
        logic       exc;
        logic [8:0] pc;
        logic       ack;
        logic [2:0] lvl;
        logic       err;
        logic       hlt;
    } vec_t;

    typedef struct {
        logic [8:0] pc;
        logic [2:0] lvl;
        logic       err;
        logic       hlt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    localparam logic [3:0] NX = 4'd0, JP = 4'd1, JI = 4'd2, JN = 4'd3;
    localparam logic [3:0] CL = 4'd4, RT = 4'd5, DP = 4'd6, WB = 4'd7;
    localparam logic [3:0] HL = 4'd8;

    function automatic vec_t v(bit rst, logic [3:0] bt, logic [8:0] tgt,
                               logic [2:0] csel, logic [7:0] fl, logic dv,
                               logic [8:0] de, logic bb, logic exc,
                               logic [8:0] pc, logic ack, logic [2:0] lvl,
                               logic err, logic hlt);
        vec_t r;
        r.rst = rst; r.bt = bt; r.tgt = tgt; r.csel = csel; r.fl = fl;
        r.dv = dv; r.de = de; r.bb = bb; r.exc = exc; r.pc = pc;
        r.ack = ack; r.lvl = lvl; r.err = err; r.hlt = hlt;
        return r;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(vec_t r, int idx);
        exp_t e;
        branch_type   = r.bt;
        branch_target = r.tgt;
        cond_sel      = r.csel;
        cond_flags    = r.fl;
        decoder_valid = r.dv;
        decoder_entry = r.de;
        bus_busy      = r.bb;
        exception_req = r.exc;
        @(negedge clock);
        chk($sformatf("row%0d micro_pc", idx), 16'(micro_pc), 16'(r.pc));
        chk($sformatf("row%0d dispatch_ack", idx), 16'(dispatch_ack), 16'(r.ack));
        sb.push_back('{pc: r.pc, lvl: r.lvl, err: r.err, hlt: r.hlt});
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("row%0d scoreboard empty", idx), 16'd0, 16'd1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("row%0d upc", idx), 16'(upc), 16'(e.pc));
            chk($sformatf("row%0d stack_level", idx), 16'(stack_level), 16'(e.lvl));
            chk($sformatf("row%0d stack_error", idx), 16'(stack_error), 16'(e.err));
            chk($sformatf("row%0d halted", idx), 16'(halted), 16'(e.hlt));
        end
    endtask

    // Inputs that would redirect and acknowledge if reset did not gate them.
    task automatic drive_busy_inputs();
        branch_type   = DP;
        decoder_valid = 1'b1;
        decoder_entry = 9'h055;
        exception_req = 1'b0;
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, " micro_pc"}, 16'(micro_pc), 16'h000);
        chk({tag, " upc"}, 16'(upc), 16'h000);
        chk({tag, " stack_level"}, 16'(stack_level), 16'd0);
        chk({tag, " halted"}, 16'(halted), 16'd0);
        chk({tag, " stack_error"}, 16'(stack_error), 16'd0);
        chk({tag, " dispatch_ack"}, 16'(dispatch_ack), 16'd0);
    endtask

    task automatic do_reset();
        drive_busy_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        @(posedge clock);
        #1;
        chk("reset_hold upc", 16'(upc), 16'h000);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(v(0, NX, 9'h000, 0, 8'h00, 0, 9'h000, 0, 0, 9'h001, 0, 0, 0, 0));
        vecs.push_back(v(0, NX, 9'h000, 0, 8'h00, 0, 9'h000, 0, 0, 9'h002, 0, 0, 0, 0));
        vecs.push_back(v(0, NX, 9'h000, 0, 8'h00, 0, 9'h000, 0, 0, 9'h003, 0, 0, 0, 0));
        vecs.push_back(v(1, JP, 9'h010, 0, 8'h00, 0, 9'h000, 0, 0, 9'h010, 0, 0, 0, 0));
        vecs.push_back(v(0, JI, 9'h080, 2, 8'h04, 0, 9'h000, 0, 0, 9'h080, 0, 0, 0, 0));
        vecs.push_back(v(0, JP, 9'h010, 0, 8'h00, 0, 9'h000, 0, 0, 9'h010, 0, 0, 0, 0));
        vecs.push_back(v(0, JI, 9'h080, 2, 8'h00, 0, 9'h000, 0, 0, 9'h011, 0, 0, 0, 0));
        vecs.push_back(v(0, JP, 9'h010, 0, 8'h00, 0, 9'h000, 0, 0, 9'h010, 0, 0, 0, 0));
        vecs.push_back(v(0, JN, 9'h080, 2, 8'h04, 0, 9'h000, 0, 0, 9'h011, 0, 0, 0, 0));
        vecs.push_back(v(0, JN, 9'h080, 5, 8'hDF, 0, 9'h000, 0, 0, 9'h080, 0, 0, 0, 0));
        vecs.push_back(v(0, JP, 9'h020, 0, 8'h00, 0, 9'h000, 0, 0, 9'h020, 0, 0, 0, 0));
        vecs.push_back(v(0, CL, 9'h100, 0, 8'h00, 0, 9'h000, 0, 0, 9'h100, 0, 1, 0, 0));
        vecs.push_back(v(0, CL, 9'h140, 0, 8'h00, 0, 9'h000, 0, 0, 9'h140, 0, 2, 0, 0));
        vecs.push_back(v(0, RT, 9'h000, 0, 8'h00, 0, 9'h000, 0, 0, 9'h101, 0, 1, 0, 0));
        vecs.push_back(v(0, RT, 9'h000, 0, 8'h00, 0, 9'h000, 0, 0, 9'h021, 0, 0, 0, 0));
        vecs.push_back(v(0, CL, 9'h100, 0, 8'h00, 0, 9'h000, 0, 0, 9'h100, 0, 1, 0, 0));
        vecs.push_back(v(0, CL, 9'h140, 0, 8'h00, 0, 9'h000, 0, 0, 9'h140, 0, 2, 0, 0));
        vecs.push_back(v(0, CL, 9'h077, 0, 8'h00, 0, 9'h000, 0, 1, 9'h1F0, 0, 0, 0, 0));
        vecs.push_back(v(0, RT, 9'h000, 0, 8'h00, 0, 9'h000, 0, 0, 9'h1FF, 0, 0, 1, 0));
        vecs.push_back(v(0, NX, 9'h000, 0, 8'h00, 0, 9'h000, 0, 0, 9'h000, 0, 0, 1, 0));
        vecs.push_back(v(0, JP, 9'h030, 0, 8'h00, 0, 9'h000, 0, 0, 9'h030, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(0, DP, 9'h000, 0, 8'h00, 0, 9'h0A5, 0, 0, 9'h030, 0, 0, 1, 0));
        vecs.push_back(v(0, DP, 9'h000, 0, 8'h00, 1, 9'h0A5, 0, 0, 9'h0A5, 1, 0, 1, 0));
        for (int i = 0; i < 2; i++)
            vecs.push_back(v(0, WB, 9'h000, 0, 8'h00, 0, 9'h000, 1, 0, 9'h0A5, 0, 0, 1, 0));
        vecs.push_back(v(0, WB, 9'h000, 0, 8'h00, 0, 9'h000, 0, 0, 9'h0A6, 0, 0, 1, 0));
        vecs.push_back(v(0, CL, 9'h100, 0, 8'h00, 0, 9'h000, 0, 0, 9'h100, 0, 1, 1, 0));
        vecs.push_back(v(0, CL, 9'h180, 0, 8'h00, 0, 9'h000, 0, 0, 9'h180, 0, 2, 1, 0));
        vecs.push_back(v(0, CL, 9'h0C0, 0, 8'h00, 0, 9'h000, 0, 0, 9'h0C0, 0, 3, 1, 0));
        vecs.push_back(v(0, CL, 9'h0E0, 0, 8'h00, 0, 9'h000, 0, 0, 9'h0E0, 0, 4, 1, 0));
        vecs.push_back(v(0, CL, 9'h050, 0, 8'h00, 0, 9'h000, 0, 0, 9'h1FF, 0, 4, 1, 0));
        vecs.push_back(v(0, RT, 9'h000, 0, 8'h00, 0, 9'h000, 0, 0, 9'h0C1, 0, 3, 1, 0));
        vecs.push_back(v(0, RT, 9'h000, 0, 8'h00, 0, 9'h000, 0, 0, 9'h181, 0, 2, 1, 0));
        vecs.push_back(v(0, JP, 9'h1FF, 0, 8'h00, 0, 9'h000, 0, 0, 9'h1FF, 0, 2, 1, 0));
        vecs.push_back(v(0, HL, 9'h000, 0, 8'h00, 0, 9'h000, 0, 0, 9'h1FF, 0, 2, 1, 1));
        for (int i = 0; i < 10; i++)
            vecs.push_back(v(0, JP, 9'h055, 0, 8'h00, 1, 9'h0A5, 0, 1, 9'h1FF, 0, 2, 1, 1));
        vecs.push_back(v(1, 4'd9, 9'h000, 0, 8'h00, 0, 9'h000, 0, 0, 9'h1FF, 0, 0, 1, 0));
        vecs.push_back(v(0, NX, 9'h000, 0, 8'h00, 0, 9'h000, 0, 0, 9'h000, 0, 0, 1, 0));
        vecs.push_back(v(1, 4'd15, 9'h000, 0, 8'h00, 0, 9'h000, 0, 0, 9'h1FF, 0, 0, 1, 0));

        drive_busy_inputs();
        repeat (2) @(posedge clock);
        #1;
        check_reset_state("initial_reset");
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            apply(vecs[i], i);
        end

        if (sb.size() != 0) chk("scoreboard drained", 16'(sb.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
